pipeline_ctrl: RTL and testbench

//  Central stall/flush sequencer for the 5-stage 16-bit pipeline (F, D, E, M, W).

---
 rtl/proc_ctrl_pkg.sv | 10 +
 rtl/pipeline_ctrl_if.sv | 36 +++
 rtl/pipeline_ctrl_load_use_detect.sv | 14 +
 rtl/pipeline_ctrl.sv | 101 ++++++++++
 tb/tb_pipeline_ctrl.sv | 276 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/proc_ctrl_pkg.sv
// proc_ctrl_pkg: shared state encodings and stage indices for the pipeline controller
package proc_ctrl_pkg;
    typedef enum logic {CTRL_RUN, CTRL_MULB} ctrl_state_e;
    localparam logic [3:0] REG_ZERO = 4'd0;
    localparam int STG_F = 0;
    localparam int STG_D = 1;
    localparam int STG_E = 2;
    localparam int STG_M = 3;
    localparam int STG_W = 4;
endpackage

// File: rtl/pipeline_ctrl_if.sv
// pipeline_ctrl_if: hazard inputs and bank write/flush controls of the pipeline controller
interface pipeline_ctrl_if;
    logic [3:0]  decode_rs1;
    logic [3:0]  decode_rs2;
    logic        decode_use_rs1;
    logic        decode_use_rs2;
    logic [3:0]  execute_rd;
    logic        execute_memread;
    logic        execute_mul;
    logic        branch_taken;
    logic        mem_req;
    logic        mem_ack;
    logic        pc_write;
    logic        fd_write;
    logic        de_write;
    logic        em_write;
    logic        mw_write;
    logic        fd_flush;
    logic        de_flush;
    logic        em_flush;
    logic        mw_flush;
    logic        mem_err;
    logic [15:0] stall_cycles;
    modport master (
        output decode_rs1, decode_rs2, decode_use_rs1, decode_use_rs2, execute_rd,
               execute_memread, execute_mul, branch_taken, mem_req, mem_ack,
        input  pc_write, fd_write, de_write, em_write, mw_write,
               fd_flush, de_flush, em_flush, mw_flush, mem_err, stall_cycles
    );
    modport slave (
        input  decode_rs1, decode_rs2, decode_use_rs1, decode_use_rs2, execute_rd,
               execute_memread, execute_mul, branch_taken, mem_req, mem_ack,
        output pc_write, fd_write, de_write, em_write, mw_write,
               fd_flush, de_flush, em_flush, mw_flush, mem_err, stall_cycles
    );
endinterface

// File: rtl/pipeline_ctrl_load_use_detect.sv
// load_use_detect: flags a D-stage read of the register an E-stage load is still fetching
module load_use_detect
    import proc_ctrl_pkg::*;
(
    input  logic [3:0] rs1,
    input  logic [3:0] rs2,
    input  logic       use_rs1,
    input  logic       use_rs2,
    input  logic [3:0] rd,
    input  logic       memread,
    output logic       hazard
);
    assign hazard = memread && rd != REG_ZERO && ((use_rs1 && rs1 == rd) || (use_rs2 && rs2 == rd));
endmodule

// File: rtl/pipeline_ctrl.sv
// pipeline_ctrl: stall/flush sequencer for the 5-stage pipeline with stall counter and memory timeout flag
module pipeline_ctrl
    import proc_ctrl_pkg::*;
#(
    parameter int MUL_LATENCY = 4,
    parameter int MEM_TIMEOUT = 255
) (
    input logic clock,
    input logic rst,
    pipeline_ctrl_if.slave bus
);
    localparam logic [2:0] MUL_INIT = 3'(MUL_LATENCY - 1);
    localparam logic [7:0] TIMEOUT = 8'(MEM_TIMEOUT);
    ctrl_state_e state, state_nxt;
    logic [2:0]  mul_cnt, mul_cnt_nxt;
    logic [7:0]  wait_cnt, wait_nxt;
    logic [15:0] stall_q;
    logic        err_q;
    logic        hazard, mem_wait, mul_busy;
    logic [4:0]  wr, fl;
    load_use_detect u_lud (
        .rs1     (bus.decode_rs1),
        .rs2     (bus.decode_rs2),
        .use_rs1 (bus.decode_use_rs1),
        .use_rs2 (bus.decode_use_rs2),
        .rd      (bus.execute_rd),
        .memread (bus.execute_memread),
        .hazard  (hazard)
    );
    always_comb begin
        mem_wait = bus.mem_req && !bus.mem_ack;
        mul_busy = (state == CTRL_RUN && bus.execute_mul && !bus.branch_taken && MUL_LATENCY > 1)
                || (state == CTRL_MULB && mul_cnt > 3'd1);
        wait_nxt = mem_wait ? wait_cnt + (wait_cnt != 8'hFF ? 8'd1 : 8'd0) : 8'd0;
        state_nxt = state;
        mul_cnt_nxt = mul_cnt;
        if (state == CTRL_RUN) begin
            if (mul_busy && !mem_wait) begin
                state_nxt = CTRL_MULB;
                mul_cnt_nxt = MUL_INIT;
            end
        end else begin
            // the count bottoms out at 1 so a memory wait can hold the multiply in E
            mul_cnt_nxt = mul_cnt > 3'd1 ? mul_cnt - 3'd1 : mul_cnt;
            if (mul_cnt == 3'd1 && !mem_wait) begin
                state_nxt = CTRL_RUN;
                mul_cnt_nxt = 3'd0;
            end
        end
        wr = '1;
        fl = '0;
        if (!rst) begin
            wr = '0;
            fl = '1;
        end else if (mem_wait) begin
            wr[STG_F] = 1'b0;
            wr[STG_D] = 1'b0;
            wr[STG_E] = 1'b0;
            wr[STG_M] = 1'b0;
            fl[STG_W] = 1'b1;
        end else if (mul_busy) begin
            wr[STG_F] = 1'b0;
            wr[STG_D] = 1'b0;
            wr[STG_E] = 1'b0;
            fl[STG_M] = 1'b1;
        end else if (bus.branch_taken) begin
            fl[STG_D] = 1'b1;
            fl[STG_E] = 1'b1;
        end else if (hazard) begin
            wr[STG_F] = 1'b0;
            wr[STG_D] = 1'b0;
            fl[STG_E] = 1'b1;
        end
    end
    always_ff @(posedge clock) begin
        if (!rst) begin
            state <= CTRL_RUN;
            mul_cnt <= 3'd0;
            wait_cnt <= 8'd0;
            err_q <= 1'b0;
            stall_q <= 16'd0;
        end else begin
            state <= state_nxt;
            mul_cnt <= mul_cnt_nxt;
            wait_cnt <= wait_nxt;
            if (mem_wait && wait_nxt == TIMEOUT) err_q <= 1'b1;
            if (!wr[STG_F] && stall_q != 16'hFFFF) stall_q <= stall_q + 16'd1;
        end
    end
    assign bus.pc_write = wr[STG_F];
    assign bus.fd_write = wr[STG_D];
    assign bus.de_write = wr[STG_E];
    assign bus.em_write = wr[STG_M];
    assign bus.mw_write = wr[STG_W];
    assign bus.fd_flush = fl[STG_D];
    assign bus.de_flush = fl[STG_E];
    assign bus.em_flush = fl[STG_M];
    assign bus.mw_flush = fl[STG_W];
    assign bus.mem_err = err_q;
    assign bus.stall_cycles = stall_q;
endmodule

// File: tb/tb_pipeline_ctrl.sv
// tb_pipeline_ctrl: directed scenarios plus randomized run against a cycle-level behavioural model
module tb_pipeline_ctrl;
    localparam int MUL_L = 4;
    localparam int TMO = 8;
    // {pc,fd,de,em,mw}_write, {fd,de,em,mw}_flush
    localparam logic [8:0] C_NORM = 9'b11111_0000;
    localparam logic [8:0] C_LU   = 9'b00111_0100;
    localparam logic [8:0] C_BR   = 9'b11111_1100;
    localparam logic [8:0] C_MUL  = 9'b00011_0010;
    localparam logic [8:0] C_WAIT = 9'b00001_0001;
    localparam logic [8:0] C_RST  = 9'b00000_1111;
    logic clock = 1'b0;
    logic rst = 1'b0;
    int checks = 0;
    int failures = 0;
    pipeline_ctrl_if bus ();
    pipeline_ctrl #(.MUL_LATENCY(MUL_L), .MEM_TIMEOUT(TMO)) dut (.clock(clock), .rst(rst), .bus(bus));
    always #5 clock = ~clock;
    wire [8:0] ctl = {bus.pc_write, bus.fd_write, bus.de_write, bus.em_write, bus.mw_write,
                      bus.fd_flush, bus.de_flush, bus.em_flush, bus.mw_flush};

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic idle();
        bus.decode_rs1 = 4'd0;
        bus.decode_rs2 = 4'd0;
        bus.decode_use_rs1 = 1'b0;
        bus.decode_use_rs2 = 1'b0;
        bus.execute_rd = 4'd0;
        bus.execute_memread = 1'b0;
        bus.execute_mul = 1'b0;
        bus.branch_taken = 1'b0;
        bus.mem_req = 1'b0;
        bus.mem_ack = 1'b1;
    endtask

    task automatic test_reset();
        idle();
        rst = 1'b0;
        #1;
        checks++;
        if (ctl !== C_RST) begin failures++; $display("FAIL reset_ctl: got %b want %b", ctl, C_RST); end
        tick();
        tick();
        rst = 1'b1;
        #1;
        checks++;
        if (ctl !== C_NORM) begin failures++; $display("FAIL reset_release_ctl: got %b want %b", ctl, C_NORM); end
        checks++;
        if (bus.stall_cycles !== 16'd0 || bus.mem_err !== 1'b0) begin
            failures++;
            $display("FAIL reset_counters: stall=%0d err=%b want 0/0", bus.stall_cycles, bus.mem_err);
        end
        tick();
    endtask

    task automatic test_load_use();
        bus.execute_memread = 1'b1;
        bus.execute_rd = 4'd3;
        bus.decode_rs1 = 4'd5;
        bus.decode_use_rs1 = 1'b1;
        bus.decode_rs2 = 4'd3;
        bus.decode_use_rs2 = 1'b1;
        #1;
        checks++;
        if (ctl !== C_LU) begin failures++; $display("FAIL load_use_ctl: got %b want %b", ctl, C_LU); end
        tick();
        bus.execute_memread = 1'b0;
        bus.execute_rd = 4'd0;
        #1;
        checks++;
        if (ctl !== C_NORM) begin failures++; $display("FAIL load_use_after: got %b want %b", ctl, C_NORM); end
        checks++;
        if (bus.stall_cycles !== 16'd1) begin failures++; $display("FAIL load_use_stall: got %0d want 1", bus.stall_cycles); end
        tick();
    endtask

    task automatic test_no_hazard();
        idle();
        bus.execute_memread = 1'b1;
        bus.decode_use_rs2 = 1'b1;
        #1;
        checks++;
        if (ctl !== C_NORM) begin failures++; $display("FAIL r0_no_hazard: got %b want %b", ctl, C_NORM); end
        tick();
        bus.execute_rd = 4'd3;
        bus.decode_rs2 = 4'd3;
        bus.branch_taken = 1'b1;
        #1;
        checks++;
        if (ctl !== C_BR) begin failures++; $display("FAIL branch_over_load_use: got %b want %b", ctl, C_BR); end
        tick();
        idle();
        #1;
        checks++;
        if (bus.stall_cycles !== 16'd1) begin failures++; $display("FAIL no_hazard_stall: got %0d want 1", bus.stall_cycles); end
    endtask

    task automatic test_multiply();
        idle();
        bus.execute_mul = 1'b1;
        for (int i = 0; i < MUL_L; i++) begin
            #1;
            checks++;
            if (ctl !== (i < MUL_L - 1 ? C_MUL : C_NORM)) begin
                failures++;
                $display("FAIL mul_cycle%0d: got %b want %b", i, ctl, i < MUL_L - 1 ? C_MUL : C_NORM);
            end
            tick();
            bus.execute_mul = 1'b0;
        end
        #1;
        checks++;
        if (ctl !== C_NORM) begin failures++; $display("FAIL mul_done_idle: got %b want %b", ctl, C_NORM); end
        bus.execute_mul = 1'b1;
        #1;
        checks++;
        if (ctl !== C_MUL) begin failures++; $display("FAIL mul_restart: got %b want %b", ctl, C_MUL); end
        tick();
        bus.execute_mul = 1'b0;
        tick();
        tick();
        tick();
        checks++;
        if (bus.stall_cycles !== 16'd7) begin failures++; $display("FAIL mul_stall: got %0d want 7", bus.stall_cycles); end
    endtask

    task automatic test_mem_wait();
        idle();
        bus.mem_req = 1'b1;
        bus.mem_ack = 1'b0;
        for (int i = 0; i < 5; i++) begin
            #1;
            checks++;
            if (ctl !== C_WAIT) begin failures++; $display("FAIL wait_cycle%0d: got %b want %b", i, ctl, C_WAIT); end
            tick();
        end
        bus.mem_ack = 1'b1;
        #1;
        checks++;
        if (ctl !== C_NORM) begin failures++; $display("FAIL wait_ack: got %b want %b", ctl, C_NORM); end
        tick();
        bus.mem_req = 1'b0;
        #1;
        checks++;
        if (bus.mem_err !== 1'b0 || bus.stall_cycles !== 16'd12) begin
            failures++;
            $display("FAIL wait_after: err=%b stall=%0d want 0/12", bus.mem_err, bus.stall_cycles);
        end
    endtask

    task automatic test_mem_timeout();
        idle();
        bus.mem_req = 1'b1;
        bus.mem_ack = 1'b0;
        for (int k = 0; k < 12; k++) begin
            #1;
            checks++;
            if (bus.mem_err !== (k >= TMO) || ctl !== C_WAIT) begin
                failures++;
                $display("FAIL timeout_wait%0d: err=%b ctl=%b want %b/%b", k, bus.mem_err, ctl, k >= TMO, C_WAIT);
            end
            tick();
        end
        bus.mem_ack = 1'b1;
        tick();
        bus.mem_req = 1'b0;
        #1;
        checks++;
        if (bus.mem_err !== 1'b1 || bus.stall_cycles !== 16'd24) begin
            failures++;
            $display("FAIL timeout_sticky: err=%b stall=%0d want 1/24", bus.mem_err, bus.stall_cycles);
        end
    endtask

    task automatic test_reset_mid_mul();
        idle();
        bus.execute_mul = 1'b1;
        tick();
        bus.execute_mul = 1'b0;
        tick();
        rst = 1'b0;
        #1;
        checks++;
        if (ctl !== C_RST) begin failures++; $display("FAIL mid_mul_reset: got %b want %b", ctl, C_RST); end
        tick();
        rst = 1'b1;
        #1;
        checks++;
        if (ctl !== C_NORM || bus.stall_cycles !== 16'd0 || bus.mem_err !== 1'b0) begin
            failures++;
            $display("FAIL mid_mul_release: ctl=%b stall=%0d err=%b want %b/0/0", ctl, bus.stall_cycles, bus.mem_err, C_NORM);
        end
        tick();
        #1;
        checks++;
        if (ctl !== C_NORM) begin failures++; $display("FAIL mid_mul_run: got %b want %b", ctl, C_NORM); end
    endtask

    task automatic test_random();
        bit in_mul = 0;
        int age = 0;
        int wait_run = 0;
        bit err = 0;
        int stall = 0;
        logic [8:0] exp;
        bit wt, hz, active;
        int cur_age;
        for (int i = 0; i < 3000; i++) begin
            rst = (i == 0) ? 1'b0 : ($urandom % 200 != 0);
            bus.decode_rs1 = 4'($urandom % 4);
            bus.decode_rs2 = 4'($urandom % 4);
            bus.decode_use_rs1 = 1'($urandom % 2);
            bus.decode_use_rs2 = 1'($urandom % 2);
            bus.execute_rd = 4'($urandom % 4);
            bus.execute_memread = ($urandom % 3 == 0);
            bus.execute_mul = ($urandom % 8 == 0);
            bus.branch_taken = ($urandom % 8 == 0);
            if ((i / 128) % 2 == 1) begin
                bus.mem_req = 1'b1;
                bus.mem_ack = ($urandom % 12 == 0);
            end else begin
                bus.mem_req = ($urandom % 3 == 0);
                bus.mem_ack = 1'($urandom % 2);
            end
            #1;
            wt = bus.mem_req && !bus.mem_ack;
            hz = bus.execute_memread && bus.execute_rd != 0 &&
                 ((bus.decode_use_rs1 && bus.decode_rs1 == bus.execute_rd) ||
                  (bus.decode_use_rs2 && bus.decode_rs2 == bus.execute_rd));
            active = in_mul || (bus.execute_mul && !bus.branch_taken && MUL_L > 1);
            cur_age = in_mul ? age : 0;
            exp = !rst ? C_RST : wt ? C_WAIT : (active && cur_age < MUL_L - 1) ? C_MUL :
                  bus.branch_taken ? C_BR : hz ? C_LU : C_NORM;
            checks++;
            if (ctl !== exp) begin failures++; $display("FAIL rand_ctl@%0d: got %b want %b", i, ctl, exp); end
            checks++;
            if (bus.mem_err !== err) begin failures++; $display("FAIL rand_err@%0d: got %b want %b", i, bus.mem_err, err); end
            checks++;
            if (bus.stall_cycles !== 16'(stall)) begin
                failures++;
                $display("FAIL rand_stall@%0d: got %0d want %0d", i, bus.stall_cycles, stall);
            end
            if (!rst) begin
                in_mul = 0; age = 0; wait_run = 0; err = 0; stall = 0;
            end else begin
                if (!exp[8] && stall < 65535) stall++;
                wait_run = wt ? (wait_run < 255 ? wait_run + 1 : 255) : 0;
                if (wt && wait_run >= TMO) err = 1;
                if (active) begin
                    if (!in_mul) begin
                        if (!wt) begin in_mul = 1; age = 1; end
                    end else if (age >= MUL_L - 1 && !wt) in_mul = 0;
                    else age++;
                end
            end
            tick();
        end
    endtask

    initial begin
        test_reset();
        test_load_use();
        test_no_hazard();
        test_multiply();
        test_mem_wait();
        test_mem_timeout();
        test_reset_mid_mul();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
